// File: rtl/yc_pkg.sv
// Shared types and helpers for the composite (Y/C) encoder.
package yc_pkg;

  localparam int YC_DATA_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PORCH,
    ST_BURST,
    ST_BLANK,
    ST_ACTIVE
  } line_state_e;

  // Clamp a signed value into the range of a w-bit two's complement word.
  function automatic int sat_signed(input int x, input int w);
    int maxv;
    int minv;
    maxv = (1 << (w - 1)) - 1;
    minv = -(1 << (w - 1));
    if (x > maxv) return maxv;
    if (x < minv) return minv;
    return x;
  endfunction

endpackage

// File: rtl/yc_chroma_mod.sv
// Subcarrier phase counter and quadrature chroma / burst term select at 4x fsc.
module yc_chroma_mod
  import yc_pkg::*;
#(
  parameter int DATA_WIDTH = YC_DATA_WIDTH,
  parameter int BURST_AMP  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         advance,
  input  logic signed [DATA_WIDTH-1:0] u,
  input  logic signed [DATA_WIDTH-1:0] v,
  input  logic                         burst_en,
  output logic signed [DATA_WIDTH:0]   chroma
);

  localparam int CW = DATA_WIDTH + 1;
  localparam logic signed [DATA_WIDTH:0] AMP = CW'(BURST_AMP);

  logic [1:0]                phase;
  logic signed [DATA_WIDTH:0] u_x;
  logic signed [DATA_WIDTH:0] v_x;

  // Phase only moves on accepted samples so backpressure cannot slip it.
  always_ff @(posedge clk) begin
    if (!rst_n)       phase <= 2'd0;
    else if (advance) phase <= phase + 2'd1;
  end

  // One extra bit so that negating the most negative input stays exact.
  assign u_x = {u[DATA_WIDTH-1], u};
  assign v_x = {v[DATA_WIDTH-1], v};

  always_comb begin
    chroma = '0;
    if (burst_en) begin
      case (phase)
        2'd0:    chroma = -AMP;
        2'd2:    chroma = AMP;
        default: chroma = '0;
      endcase
    end else begin
      case (phase)
        2'd0:    chroma = u_x;
        2'd1:    chroma = v_x;
        2'd2:    chroma = -u_x;
        default: chroma = -v_x;
      endcase
    end
  end

endmodule

// File: rtl/yc_combiner.sv
// Composite encoder: quadrature chroma + luma, saturate, with sync/blank/burst insertion.
module yc_combiner
  import yc_pkg::*;
#(
  parameter int DATA_WIDTH  = YC_DATA_WIDTH,
  parameter int BURST_START = 20,
  parameter int BURST_LEN   = 36,
  parameter int BURST_AMP   = 256,
  parameter int SYNC_LEVEL  = -1024,
  parameter int BLANK_LEVEL = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] luma_in,
  input  logic signed [DATA_WIDTH-1:0] u_in,
  input  logic signed [DATA_WIDTH-1:0] v_in,
  input  logic                         sync_in,
  input  logic                         blank_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] comp_out
);

  localparam logic signed [DATA_WIDTH-1:0] SYNC_V  = DATA_WIDTH'(SYNC_LEVEL);
  localparam logic signed [DATA_WIDTH-1:0] BLANK_V = DATA_WIDTH'(BLANK_LEVEL);
  localparam logic [15:0] PORCH_END = 16'(BURST_START - 1);
  localparam logic [15:0] BURST_END = 16'(BURST_START + BURST_LEN - 1);

  function automatic logic signed [DATA_WIDTH-1:0] sat_out(input logic signed [DATA_WIDTH:0] x);
    return DATA_WIDTH'(sat_signed(int'(x), DATA_WIDTH));
  endfunction

  logic                         vld_p1, vld_p2;
  logic                         adv_p2, accept;
  line_state_e                  state, nxt_state;
  logic [15:0]                  cnt, nxt_cnt;
  logic signed [DATA_WIDTH:0]   chroma;
  logic signed [DATA_WIDTH-1:0] base_nxt, base_p1;
  logic signed [DATA_WIDTH:0]   add_nxt, add_p1;
  logic signed [DATA_WIDTH:0]   sum_p1;
  logic signed [DATA_WIDTH-1:0] comp_p2;

  assign adv_p2   = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv_p2;
  assign accept   = in_valid && in_ready;

  yc_chroma_mod #(
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_AMP  (BURST_AMP)
  ) u_chroma (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (accept),
    .u        (u_in),
    .v        (v_in),
    .burst_en (nxt_state == ST_BURST),
    .chroma   (chroma)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
    end else if (accept) begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // Next state is resolved from the sample being accepted; that sample already uses it.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    if (state == ST_SYNC && !sync_in) nxt_cnt = 16'd0;
    if (sync_in) begin
      nxt_state = ST_SYNC;
    end else begin
      case (state)
        ST_IDLE:   nxt_state = ST_IDLE;
        ST_SYNC:   nxt_state = ST_PORCH;
        ST_PORCH:  if (!blank_in) nxt_state = ST_ACTIVE;
                   else if (cnt == PORCH_END) nxt_state = ST_BURST;
        ST_BURST:  if (!blank_in) nxt_state = ST_ACTIVE;
                   else if (cnt == BURST_END) nxt_state = ST_BLANK;
        ST_BLANK:  if (!blank_in) nxt_state = ST_ACTIVE;
        ST_ACTIVE: if (blank_in) nxt_state = ST_BLANK;
        default:   nxt_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    base_nxt = BLANK_V;
    add_nxt  = '0;
    case (nxt_state)
      ST_SYNC:   base_nxt = SYNC_V;
      ST_BURST:  add_nxt  = chroma;
      ST_ACTIVE: begin
        base_nxt = luma_in;
        add_nxt  = chroma;
      end
      default:   base_nxt = BLANK_V;
    endcase
  end

  // Stage 1: modulate/classify -> base level plus additive chroma term
  always_ff @(posedge clk) begin
    if (!rst_n)        vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      base_p1 <= base_nxt;
      add_p1  <= add_nxt;
    end
  end

  assign sum_p1 = {base_p1[DATA_WIDTH-1], base_p1} + add_p1;

  // Stage 2: sum/saturate -> registered composite output
  always_ff @(posedge clk) begin
    if (!rst_n)      vld_p2 <= 1'b0;
    else if (adv_p2) vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                comp_p2 <= '0;
    else if (adv_p2 && vld_p1) comp_p2 <= sat_out(sum_p1);
  end

  assign out_valid = vld_p2;
  assign comp_out  = comp_p2;

endmodule

// File: tb/tb_yc_combiner.sv
// Directed and randomized-backpressure bench for the composite encoder.
module tb_yc_combiner;

  localparam int DW = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] luma_in = '0;
  logic signed [DW-1:0] u_in = '0;
  logic signed [DW-1:0] v_in = '0;
  logic                 sync_in = 1'b0;
  logic                 blank_in = 1'b1;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] comp_out;

  int checks = 0;
  int failures = 0;
  int outq[$];
  int expq[$];
  int dq[$];
  bit use_model = 0;
  bit bp_en = 0;

  always #5 clk = ~clk;

  yc_combiner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .luma_in   (luma_in),
    .u_in      (u_in),
    .v_in      (v_in),
    .sync_in   (sync_in),
    .blank_in  (blank_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .comp_out  (comp_out)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model, written from the line timing description
  int m_mode, m_pos, m_ph;
  function automatic int clamp(input int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic int model_step(input int l, input int u, input int v, input bit s, input bit b);
    int c;
    int r;
    case (m_ph)
      0: c = u;
      1: c = v;
      2: c = -u;
      default: c = -v;
    endcase
    if (s) m_mode = 1;
    else if (m_mode == 1) begin m_mode = 2; m_pos = 0; end
    else if (m_mode == 2) begin
      m_pos++;
      if (!b) m_mode = 4;
      else if (m_pos >= 56) m_mode = 3;
    end
    else if (m_mode == 3 && !b) m_mode = 4;
    else if (m_mode == 4 && b) m_mode = 3;
    case (m_mode)
      1: r = -1024;
      2: r = (m_pos >= 20) ? ((m_ph == 0) ? -256 : (m_ph == 2) ? 256 : 0) : 0;
      4: r = clamp(l + c);
      default: r = 0;
    endcase
    m_ph = (m_ph + 1) % 4;
    return r;
  endfunction

  // Output monitor: records transfers and checks that stalled data holds
  logic signed [DW-1:0] held;
  bit holding = 0;
  always @(negedge clk) begin
    if (!rst_n) holding = 0;
    else begin
      if (holding) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(comp_out), int'(held));
      end
      if (out_valid && out_ready) begin
        outq.push_back(int'(comp_out));
        holding = 0;
      end else if (out_valid) begin
        held = comp_out;
        holding = 1;
      end else holding = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input int l, input int u, input int v, input bit s, input bit b);
    int t;
    t = 0;
    luma_in = DW'(l); u_in = DW'(u); v_in = DW'(v);
    sync_in = s; blank_in = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    if (use_model) expq.push_back(model_step(l, u, v, s, b));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pushn(input int val, input int n);
    repeat (n) dq.push_back(val);
  endtask

  task automatic expect_seq(input string tag);
    idle(6);
    chk({tag, "_count"}, outq.size(), dq.size());
    for (int i = 0; i < dq.size() && i < outq.size(); i++) chk(tag, outq[i], dq[i]);
    outq.delete();
    dq.delete();
  endtask

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic rsend(input int l, input bit s, input bit b);
    if ($urandom_range(0, 9) < 3) begin
      luma_in = DW'(rnd12());
      idle(1);
    end
    send(l, rnd12(), rnd12(), s, b);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    // Reset and first-sample latency
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_comp_out", int'(comp_out), 0);
    @(posedge clk); #1;
    send(0, 0, 0, 1, 0);
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    chk("latency_c1", int'(out_valid), 0);
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("latency", lat, 2);
    @(posedge clk); #1;
    send(0, 0, 0, 0, 0);
    send(100, 0, 0, 0, 0);
    send(100, 0, 0, 0, 0);
    dq = '{-1024, 0, 100, 100};
    expect_seq("first");

    // Quadrature modulation over two subcarrier cycles
    repeat (8) send(0, 300, -200, 0, 0);
    dq = '{300, -200, -300, 200, 300, -200, -300, 200};
    expect_seq("mod");

    // Saturation at both rails, including negated most-negative inputs
    send(2000, 200, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(-2000, 200, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    send(-2048, -2048, 0, 0, 0);
    send(2047, 0, 2047, 0, 0);
    send(0, -2048, 0, 0, 0);
    send(0, 0, -2048, 0, 0);
    dq = '{2047, 0, -2048, 0, -2048, 2047, 2047, 2047};
    expect_seq("sat");

    // Full line timing: sync, porch, burst, blank, back to active
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    repeat (10) send(700, 0, 0, 1, 1);
    repeat (100) send(700, 0, 0, 0, 1);
    send(5, 0, 0, 0, 0);
    send(5, 0, 0, 0, 0);
    pushn(0, 2);
    pushn(-1024, 10);
    pushn(0, 20);
    repeat (9) begin dq.push_back(-256); dq.push_back(0); dq.push_back(256); dq.push_back(0); end
    pushn(0, 44);
    pushn(5, 2);
    expect_seq("line");

    // Sync arriving mid-burst cuts it and restarts the porch
    repeat (10) send(0, 0, 0, 1, 1);
    repeat (24) send(0, 0, 0, 0, 1);
    send(0, 0, 0, 1, 1);
    repeat (20) send(0, 0, 0, 0, 1);
    pushn(-1024, 10);
    pushn(0, 20);
    dq.push_back(-256); dq.push_back(0); dq.push_back(256); dq.push_back(0);
    dq.push_back(-1024);
    pushn(0, 20);
    expect_seq("midburst");

    // Reset while samples are in flight
    send(300, 0, 0, 1, 0);
    send(300, 0, 0, 1, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_comp_out", int'(comp_out), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    idle(5);
    chk("midrst_dropped", outq.size(), 0);
    outq.delete();

    // Random backpressure against the reference model
    m_mode = 0; m_pos = 0; m_ph = 0;
    use_model = 1;
    bp_en = 1;
    n = 0;
    while (n < 10000) begin
      int len;
      len = $urandom_range(1, 12);
      repeat (len) begin rsend(rnd12(), 1, 1'($urandom_range(0, 1))); n++; end
      len = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(1, 70);
      repeat (len) begin rsend(rnd12(), 0, 1); n++; end
      if ($urandom_range(0, 3) != 0) begin
        len = $urandom_range(1, 150);
        repeat (len) begin rsend(rnd12(), 0, 0); n++; end
      end
    end
    in_valid = 1'b0;
    bp_en = 0;
    idle(10);
    chk("rand_count", outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++) chk("rand_data", outq[i], expq[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
